// File: rtl/bcd_stopwatch.sv
// ============================================================================
// Module   : bcd_stopwatch
// Brief    : mm:ss BCD stopwatch advanced by a synchronized slow tick, with a
//            registered 4-digit common-anode 7-segment scan.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_stopwatch #(
  parameter int SCAN_DIV        = 50000,
  parameter bit TICK_BOTH_EDGES = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       run_btn,
  input  logic       clr_btn,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       wrap,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int              SCAN_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  // Shift chains: [0] first sync stage, [1] second sync stage, [2] history.
  logic [2:0] tick_sh_q, tick_sh_d;
  logic [2:0] run_sh_q,  run_sh_d;
  logic [2:0] clr_sh_q,  clr_sh_d;
  logic       tick_ev_q, tick_ev_d;
  logic       run_ev_q,  run_ev_d;
  logic       clr_ev_q,  clr_ev_d;
  logic       tick_edge;

  logic [3:0] sec_ones_q, sec_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [3:0] min_tens_q, min_tens_d;
  logic       running_q,  running_d;
  logic       wrap_q,     wrap_d;

  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]        scan_idx_q, scan_idx_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [3:0]        shown_digit;

  generate
    if (TICK_BOTH_EDGES) begin : g_tick_both
      assign tick_edge = tick_sh_q[1] ^ tick_sh_q[2];
    end else begin : g_tick_rise
      assign tick_edge = tick_sh_q[1] & ~tick_sh_q[2];
    end
  endgenerate

  // Events are registered once more so an input edge lands in state at k+3.
  always_comb begin
    tick_sh_d = {tick_sh_q[1:0], tick_in};
    run_sh_d  = {run_sh_q[1:0],  run_btn};
    clr_sh_d  = {clr_sh_q[1:0],  clr_btn};
    tick_ev_d = tick_edge;
    run_ev_d  = run_sh_q[1] & ~run_sh_q[2];
    clr_ev_d  = clr_sh_q[1] & ~clr_sh_q[2];
  end

  always_comb begin
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    running_d  = running_q;
    wrap_d     = 1'b0;

    if (clr_ev_q) begin
      sec_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      min_ones_d = 4'd0;
      min_tens_d = 4'd0;
    end else if (tick_ev_q && running_q) begin
      // >= comparisons fold any out-of-range value back to zero.
      if (sec_ones_q >= 4'd9) begin
        sec_ones_d = 4'd0;
        if (sec_tens_q >= 4'd5) begin
          sec_tens_d = 4'd0;
          if (min_ones_q >= 4'd9) begin
            min_ones_d = 4'd0;
            if (min_tens_q >= 4'd5) begin
              min_tens_d = 4'd0;
              wrap_d     = 1'b1;
            end else begin
              min_tens_d = min_tens_q + 4'd1;
            end
          end else begin
            min_ones_d = min_ones_q + 4'd1;
          end
        end else begin
          sec_tens_d = sec_tens_q + 4'd1;
        end
      end else begin
        sec_ones_d = sec_ones_q + 4'd1;
      end
    end

    if (run_ev_q) begin
      running_d = ~running_q;
    end
  end

  // Display registers follow the next index and next digit values together.
  always_comb begin
    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      scan_idx_d = scan_idx_q + 2'd1;
    end

    an_d        = 4'b1110;
    dp_d        = 1'b1;
    shown_digit = sec_ones_d;
    case (scan_idx_d)
      2'd0: begin an_d = 4'b1110; shown_digit = sec_ones_d; end
      2'd1: begin an_d = 4'b1101; shown_digit = sec_tens_d; end
      2'd2: begin an_d = 4'b1011; shown_digit = min_ones_d; dp_d = 1'b0; end
      default: begin an_d = 4'b0111; shown_digit = min_tens_d; end
    endcase

    case (shown_digit)
      4'd0:    seg_d = 7'b1000000;
      4'd1:    seg_d = 7'b1111001;
      4'd2:    seg_d = 7'b0100100;
      4'd3:    seg_d = 7'b0110000;
      4'd4:    seg_d = 7'b0011001;
      4'd5:    seg_d = 7'b0010010;
      4'd6:    seg_d = 7'b0000010;
      4'd7:    seg_d = 7'b1111000;
      4'd8:    seg_d = 7'b0000000;
      4'd9:    seg_d = 7'b0010000;
      default: seg_d = 7'b1111111;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_sh_q  <= 3'b000;
      run_sh_q   <= 3'b000;
      clr_sh_q   <= 3'b000;
      tick_ev_q  <= 1'b0;
      run_ev_q   <= 1'b0;
      clr_ev_q   <= 1'b0;
      sec_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      min_tens_q <= 4'd0;
      running_q  <= 1'b0;
      wrap_q     <= 1'b0;
      scan_cnt_q <= '0;
      scan_idx_q <= 2'd0;
      an_q       <= 4'b1110;
      seg_q      <= 7'b1000000;
      dp_q       <= 1'b1;
    end else begin
      tick_sh_q  <= tick_sh_d;
      run_sh_q   <= run_sh_d;
      clr_sh_q   <= clr_sh_d;
      tick_ev_q  <= tick_ev_d;
      run_ev_q   <= run_ev_d;
      clr_ev_q   <= clr_ev_d;
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      min_ones_q <= min_ones_d;
      min_tens_q <= min_tens_d;
      running_q  <= running_d;
      wrap_q     <= wrap_d;
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign sec_ones = sec_ones_q;
  assign sec_tens = sec_tens_q;
  assign min_ones = min_ones_q;
  assign min_tens = min_tens_q;
  assign running  = running_q;
  assign wrap     = wrap_q;
  assign an       = an_q;
  assign seg      = seg_q;
  assign dp       = dp_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_stopwatch.sv
// ============================================================================
// Module   : tb_bcd_stopwatch
// Brief    : directed scoreboard bench for bcd_stopwatch (rising-edge and
//            both-edge tick variants side by side, fast display scan).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bcd_stopwatch;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic tick_in = 1'b0;
  logic run_btn = 1'b0;
  logic clr_btn = 1'b0;

  logic [3:0] so_a, st_a, mo_a, mt_a, an_a;
  logic [6:0] seg_a;
  logic       run_a, wrap_a, dp_a;
  logic [3:0] so_b, st_b, mo_b, mt_b, an_b;
  logic [6:0] seg_b;
  logic       run_b, wrap_b, dp_b;

  always #5 clock = ~clock;

  bcd_stopwatch #(.SCAN_DIV(4), .TICK_BOTH_EDGES(1'b0)) dut (
    .clock(clock), .reset(reset), .tick_in(tick_in), .run_btn(run_btn), .clr_btn(clr_btn),
    .sec_ones(so_a), .sec_tens(st_a), .min_ones(mo_a), .min_tens(mt_a),
    .running(run_a), .wrap(wrap_a), .an(an_a), .seg(seg_a), .dp(dp_a)
  );

  bcd_stopwatch #(.SCAN_DIV(4), .TICK_BOTH_EDGES(1'b1)) dut_b (
    .clock(clock), .reset(reset), .tick_in(tick_in), .run_btn(run_btn), .clr_btn(clr_btn),
    .sec_ones(so_b), .sec_tens(st_b), .min_ones(mo_b), .min_tens(mt_b),
    .running(run_b), .wrap(wrap_b), .an(an_b), .seg(seg_b), .dp(dp_b)
  );

  wire [15:0] digits_a = {mt_a, mo_a, st_a, so_a};
  wire [15:0] digits_b = {mt_b, mo_b, st_b, so_b};

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_v(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check_v(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %0h, nothing expected", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.val);
      end
    end
  endtask

  // Advance n clocks and land 1 time unit after the last rising edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick_in = 1'b1;
      cyc(3);
      tick_in = 1'b0;
      cyc(3);
    end
    cyc(2);
  endtask

  task automatic press_run();
    run_btn = 1'b1;
    cyc(3);
    run_btn = 1'b0;
    cyc(3);
  endtask

  task automatic press_clr();
    clr_btn = 1'b1;
    cyc(3);
    clr_btn = 1'b0;
    cyc(3);
  endtask

  logic [3:0]  an_exp [4];
  logic [6:0]  seg_exp [4];
  logic [3:0]  prev_an;
  logic [15:0] wrap_digits;
  int          wraps;
  bit          found;

  initial begin
    an_exp  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_exp = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

    // Reset held with tick_in already high.
    reset = 1'b0; tick_in = 1'b1;
    cyc(2);
    expect_v("rst_an", 4'b1110);       check_v(an_a);
    expect_v("rst_seg", 7'b1000000);   check_v(seg_a);
    expect_v("rst_dp", 1'b1);          check_v(dp_a);
    expect_v("rst_wrap", 1'b0);        check_v(wrap_a);
    expect_v("rst_digits", 16'h0000);  check_v(digits_a);
    expect_v("rst_running", 1'b0);     check_v(run_a);
    reset = 1'b1;
    cyc(8);
    expect_v("rel_tick_high_digits", 16'h0000); check_v(digits_a);
    expect_v("rel_tick_high_running", 1'b0);    check_v(run_a);
    tick_in = 1'b0;
    cyc(4);

    press_run();
    expect_v("run_on", 1'b1); check_v(run_a);

    // First tick: latency of exactly three clocks from the sampling edge.
    tick_in = 1'b1;
    cyc(3);
    expect_v("lat_k+2_old", 4'd0); check_v(so_a);
    cyc(1);
    expect_v("lat_k+3_new", 4'd1); check_v(so_a);
    tick_in = 1'b0;
    cyc(3);
    tick_n(9);
    expect_v("ten_ticks", 16'h0010); check_v(digits_a);

    // Preload 59:58, then 59:59, then wrap to 00:00.
    press_clr();
    expect_v("clr_digits", 16'h0000); check_v(digits_a);
    expect_v("clr_keeps_run", 1'b1);  check_v(run_a);
    tick_n(3598);
    expect_v("preload_5958", 16'h5958); check_v(digits_a);
    tick_n(1);
    expect_v("at_5959", 16'h5959); check_v(digits_a);
    expect_v("no_wrap_yet", 1'b0); check_v(wrap_a);
    wraps = 0;
    wrap_digits = 16'hFFFF;
    tick_in = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cyc(1);
      if (wrap_a) begin
        wraps++;
        wrap_digits = digits_a;
      end
      if (c == 2) tick_in = 1'b0;
    end
    expect_v("wrap_pulse_count", 1);       check_v(wraps);
    expect_v("wrap_digits", 16'h0000);     check_v(wrap_digits);

    // Clear and tick arriving together at 00:07.
    tick_n(7);
    expect_v("at_0007", 16'h0007); check_v(digits_a);
    tick_in = 1'b1; clr_btn = 1'b1;
    cyc(3);
    tick_in = 1'b0; clr_btn = 1'b0;
    cyc(5);
    expect_v("clr_beats_tick", 16'h0000); check_v(digits_a);
    expect_v("clr_tick_running", 1'b1);   check_v(run_a);

    // Run toggle and tick together at 00:03: tick uses old running.
    tick_n(3);
    expect_v("at_0003", 16'h0003); check_v(digits_a);
    tick_in = 1'b1; run_btn = 1'b1;
    cyc(3);
    tick_in = 1'b0; run_btn = 1'b0;
    cyc(5);
    expect_v("run_tick_digits", 16'h0004); check_v(digits_a);
    expect_v("run_tick_stopped", 1'b0);    check_v(run_a);
    tick_n(2);
    expect_v("paused_no_count", 16'h0004); check_v(digits_a);

    // Rising-only vs both-edge tick on identical stimulus.
    press_clr();
    press_run();
    tick_n(5);
    expect_v("rise_only_5", 16'h0005);  check_v(digits_a);
    expect_v("both_edges_10", 16'h0010); check_v(digits_b);

    // Display scan at 12:34.
    press_clr();
    tick_n(754);
    press_run();
    expect_v("at_1234", 16'h1234); check_v(digits_a);
    expect_v("stopped_1234", 1'b0); check_v(run_a);
    found = 1'b0;
    prev_an = an_a;
    for (int c = 0; c < 40 && !found; c++) begin
      cyc(1);
      if (prev_an == 4'b0111 && an_a == 4'b1110) found = 1'b1;
      prev_an = an_a;
    end
    expect_v("scan_align", 1'b1); check_v(found);
    for (int i = 0; i < 16; i++) begin
      expect_v($sformatf("scan_an_%0d", i), an_exp[i/4]);                 check_v(an_a);
      expect_v($sformatf("scan_seg_%0d", i), seg_exp[i/4]);               check_v(seg_a);
      expect_v($sformatf("scan_dp_%0d", i), (i/4 == 2) ? 1'b0 : 1'b1);   check_v(dp_a);
      cyc(1);
    end

    // Reset mid-scan takes effect without waiting for a clock edge.
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (an_a == 4'b1011) found = 1'b1;
      else cyc(1);
    end
    expect_v("scan_reach_idx2", 1'b1); check_v(found);
    #2 reset = 1'b0;
    #1;
    expect_v("async_rst_an", 4'b1110);      check_v(an_a);
    expect_v("async_rst_seg", 7'b1000000);  check_v(seg_a);
    expect_v("async_rst_dp", 1'b1);         check_v(dp_a);
    expect_v("async_rst_digits", 16'h0000); check_v(digits_a);
    cyc(2);
    reset = 1'b1;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
